// File: rtl/trig_sched.sv
// trig_sched: trigger scheduler between the pair discriminators and readout.
// Merges single-cycle trigger pulses seen within a programmable coincidence
// window into one record (source mask + sequence number), offers it to
// readout, then holds off for a programmable dead time. Drives the common
// inhibit back to the discriminators and counts activity lost while busy.
//
// Optional feature macro: TRIG_SCHED_TIMESTAMP_EN adds a 32-bit free-running
// counter and the ttime output (counter value at the capture cycle).
//
// Ports:
//   ADCCLK      in   sole clock
//   reset       in   synchronous, active-high reset
//   trig_in     in   [NPAIR]   pair trigger pulses
//   exttrig     in   external trigger pulse
//   enable      in   arms the scheduler; low blocks new records
//   win_len     in   [4]   coincidence window length, cycles
//   dead_len    in   [16]  dead time after acceptance, cycles
//   inhibit_out out  common inhibit to the pair discriminators (registered)
//   tvalid      out  record valid
//   tready      in   readout accepts record
//   tmask       out  [NPAIR+1] source mask, bit NPAIR = exttrig
//   tcount      out  [16] sequence number of the current record
//   lost_cnt    out  [16] saturating count of busy cycles with input activity
//   ttime       out  [32] capture timestamp (TRIG_SCHED_TIMESTAMP_EN only)
//   state_dbg   out  [2]  current FSM state (0 IDLE, 1 GATE, 2 ISSUE, 3 DEAD)
//
// Handshake: a record transfers in any cycle where tvalid & tready are both
// high; once tvalid rises, tmask/tcount/ttime stay stable and tvalid stays
// high until that transfer, whatever tready does.

module trig_sched #(
    parameter int NPAIR = 8
) (
    input  logic             ADCCLK,
    input  logic             reset,
    input  logic [NPAIR-1:0] trig_in,
    input  logic             exttrig,
    input  logic             enable,
    input  logic [3:0]       win_len,
    input  logic [15:0]      dead_len,
    output logic             inhibit_out,
    output logic             tvalid,
    input  logic             tready,
    output logic [NPAIR:0]   tmask,
    output logic [15:0]      tcount,
    output logic [15:0]      lost_cnt,
`ifdef TRIG_SCHED_TIMESTAMP_EN
    output logic [31:0]      ttime,
`endif
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        ISSUE = 2'd2,
        DEAD  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    timer_q, timer_d;
    logic [NPAIR:0] tmask_q, tmask_d;
    logic [15:0]    tcount_q, tcount_d;
    logic [15:0]    lost_q, lost_d;
    logic           tvalid_q, inhibit_q;
    logic           any_in, capture, busy;
    logic [NPAIR:0] in_vec;

    assign in_vec = {exttrig, trig_in};
    assign any_in = (|trig_in) | exttrig;
    assign busy   = (state_q == ISSUE) || (state_q == DEAD);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        tmask_d  = tmask_q;
        tcount_d = tcount_q;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && any_in) begin
                    capture = 1'b1;
                    tmask_d = in_vec;
                    timer_d = {12'd0, win_len};
                    state_d = (win_len != 4'd0) ? GATE : ISSUE;
                end
            end
            GATE: begin
                // timer counts the remaining window cycles including this one
                tmask_d = tmask_q | in_vec;
                timer_d = timer_q - 16'd1;
                if (timer_q == 16'd1) state_d = ISSUE;
            end
            ISSUE: begin
                if (tready) begin
                    tcount_d = tcount_q + 16'd1;
                    if (dead_len != 16'd0) begin
                        state_d = DEAD;
                        timer_d = dead_len;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DEAD: begin
                timer_d = timer_q - 16'd1;
                if (timer_q == 16'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        lost_d = lost_q;
        if (busy && any_in && (lost_q != 16'hFFFF)) lost_d = lost_q + 16'd1;
    end

    always_ff @(posedge ADCCLK) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= 16'd0;
            tmask_q   <= '0;
            tcount_q  <= 16'd0;
            lost_q    <= 16'd0;
            tvalid_q  <= 1'b0;
            inhibit_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            tmask_q   <= tmask_d;
            tcount_q  <= tcount_d;
            lost_q    <= lost_d;
            // registered from the next state so both rise in the ISSUE entry cycle
            tvalid_q  <= (state_d == ISSUE);
            inhibit_q <= (state_d == ISSUE) || (state_d == DEAD) || !enable;
        end
    end

`ifdef TRIG_SCHED_TIMESTAMP_EN
    logic [31:0] ts_q, ttime_q;

    always_ff @(posedge ADCCLK) begin
        if (reset) begin
            ts_q    <= 32'd0;
            ttime_q <= 32'd0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (capture) ttime_q <= ts_q;
        end
    end

    assign ttime = ttime_q;
`endif

    assign inhibit_out = inhibit_q;
    assign tvalid      = tvalid_q;
    assign tmask       = tmask_q;
    assign tcount      = tcount_q;
    assign lost_cnt    = lost_q;
    assign state_dbg   = state_q;

endmodule

// File: doc/trig_sched.md
# trig_sched

Trigger scheduler sitting between the per-pair coincidence discriminators (up to NPAIR two-channel trigger units plus the external trigger) and the event readout. It merges their single-cycle trigger pulses within a programmable coincidence window into one trigger record with a source mask. It hands the record to readout over a valid/ready handshake, then enforces a programmable dead time. It drives the common inhibit back to all pair discriminators and counts triggers lost while busy.

## Interface
- NPAIR, 8, number of pair-trigger inputs (1..16)
- ADCCLK  in  1  ADC clock, sole clock
- reset  in  1  synchronous, active-high reset
- trig_in  in  NPAIR  single-cycle trigger pulses from pair discriminators, ADCCLK-synchronous
- exttrig  in  1  external trigger pulse, already synchronised to ADCCLK
- enable  in  1  arms the scheduler; low blocks new records
- win_len  in  4  coincidence window length, cycles (0..15)
- dead_len  in  16  dead time after record acceptance, cycles
- inhibit_out  out  1  common inhibit to all pair discriminators
- tvalid  out  1  trigger record valid
- tready  in  1  readout accepts record
- tmask  out  NPAIR+1  source mask; bit NPAIR = exttrig
- tcount  out  16  sequence number of the current record
- lost_cnt  out  16  saturating count of cycles with input activity while busy

## Operation
- States: IDLE, GATE, ISSUE, DEAD. Reset -> IDLE.
- Define any_in = |trig_in | exttrig.
- IDLE:
  - Capture occurs when enable & any_in.
  - On capture: tmask <= {exttrig, trig_in}; timer <= win_len; timestamp captured.
  - On capture, next state is GATE if win_len != 0, else ISSUE.
- GATE:
  - Each cycle: tmask <= tmask | {exttrig, trig_in}; timer decrements.
  - When timer reaches 1, the next state is ISSUE.
  - The GATE state lasts exactly win_len cycles.
  - enable is ignored in GATE.
- ISSUE:
  - tvalid = 1; tmask, tcount and ttime are held stable.
  - On tvalid & tready: tcount <= tcount + 1, wrapping 0xFFFF -> 0.
  - On acceptance, next state is DEAD with timer <= dead_len, or IDLE if dead_len == 0.
- DEAD: timer decrements; at 1 the next state is IDLE. Duration is exactly dead_len cycles.
- lost_cnt:
  - Increments by 1 in every ISSUE or DEAD cycle where any_in = 1.
  - Saturates at 0xFFFF; cleared only by reset.
- inhibit_out = 1 when the state is ISSUE or DEAD, when enable = 0, or while reset is asserted. Otherwise 0. It is a registered output.
- win_len and dead_len are sampled only when the timer is loaded. Changes mid-window or mid-dead-time take effect on the next record.
- Reset mid-operation:
  - Aborts any pending record; tvalid drops the cycle after reset.
  - Clears tcount, lost_cnt and the timestamp.
  - No partial record is emitted.

## Timing
- Reset values: tvalid = 0, tmask = 0, tcount = 0, lost_cnt = 0, inhibit_out = 1, ttime = 0.
- Capture cycle is c0, with the state in IDLE.
  - GATE occupies c1..c(win_len); inputs in those cycles are ORed into tmask.
  - tvalid rises at c(win_len+1).
  - win_len = 0 gives tvalid at c1, with the mask taken from c0 only.
- A handshake completing in the same cycle tvalid rises costs no extra cycle.
- After acceptance at cycle a:
  - The state is DEAD for a+1..a+dead_len.
  - IDLE resumes at a+dead_len+1, with inhibit_out low in that cycle if enable = 1.
- inhibit_out rises in the cycle tvalid rises. Downstream discriminators register inhibit again, so pair triggers can still arrive for 1 cycle after ISSUE entry; these count in lost_cnt.
- Simultaneous handshake completion and any_in in ISSUE: lost_cnt increments, and no new capture occurs that cycle.

## Configuration
- TRIG_SCHED_TIMESTAMP_EN:
  - Defined: adds port ttime (out, 32) and a 32-bit free-running counter. The counter is cleared by reset and wraps at 2^32. ttime holds the counter value at capture cycle c0 and is stable while tvalid = 1.
  - Undefined: no counter and no ttime port; all other behaviour is identical.

## Test plan
- Single pair trigger: win_len = 3, dead_len = 10, trig_in[2] pulse at c0 -> tvalid at c4, tmask = 0x004, tcount = 0; tready held high -> inhibit_out low again at c15.
- Coincidence merge: win_len = 3, trig_in[0] at c0, exttrig at c2, trig_in[5] at c4 -> tmask = 0x101. The c4 pulse arrives during ISSUE: lost_cnt = 1.
- Backpressure: tready low for 20 cycles -> tmask, tcount and ttime stable throughout, inhibit_out = 1, and one lost_cnt increment per active cycle. After accept, tcount = 1.
- Edge lengths: win_len = 0, dead_len = 0, triggers every other cycle with tready = 1 -> a record every 2 cycles, lost_cnt = 0. tcount preset via 65536 accepts wraps to 0.
- Enable/reset: enable = 0 with triggers -> no tvalid, inhibit_out = 1, lost_cnt unchanged. Reset asserted in ISSUE -> tvalid = 0 next cycle, and all counters are 0.
- With TRIG_SCHED_TIMESTAMP_EN: captures at cycles 100 and 250 after reset -> ttime = 100 and 250.
